// File: rtl/alu_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer_pkg
// Brief    : Shared encodings and field widths for the ALU command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_cmd_sequencer_pkg;

    localparam int REG_AW = 5;
    localparam int OP_W   = 3;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_AND = 3'd0;
    localparam logic [OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR = 3'd2;
    localparam logic [OP_W-1:0] OP_INC = 3'd3;
    localparam logic [OP_W-1:0] OP_ADD = 3'd4;
    localparam logic [OP_W-1:0] OP_SUB = 3'd5;
    localparam logic [OP_W-1:0] OP_SLT = 3'd6;
    localparam logic [OP_W-1:0] OP_SLL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    function automatic logic is_zero_reg(input logic [REG_AW-1:0] addr);
        return (addr == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer_if
// Brief    : Command, datapath and result signals of the ALU command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if;
    import alu_cmd_sequencer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [REG_AW-1:0] cmd_rd;
    logic [REG_AW-1:0] cmd_rs;
    logic [REG_AW-1:0] cmd_rt;

    logic [REG_AW-1:0] R_Addr_A;
    logic [REG_AW-1:0] R_Addr_B;
    logic [REG_AW-1:0] W_Addr;
    logic [OP_W-1:0]   ALU_OP;
    logic              Write_Reg;
    logic [DATA_W-1:0] alu_F;
    logic              alu_ZF;
    logic              alu_OF;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_zf;
    logic              res_of;
    logic              res_wrote;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
        input  alu_F, alu_ZF, alu_OF, res_ready,
        output cmd_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Write_Reg,
        output res_valid, res_data, res_zf, res_of, res_wrote
    );

    // Command source / datapath / result consumer side
    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
        output alu_F, alu_ZF, alu_OF, res_ready,
        input  cmd_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Write_Reg,
        input  res_valid, res_data, res_zf, res_of, res_wrote
    );

endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : IDLE/EXEC/RESP front-end driving register file + ALU addresses.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter bit PROTECT_R0 = 1'b1,
    parameter bit TRAP_ON_OF = 1'b1,
    parameter int CNT_W      = 16
) (
    input  wire logic             clk,
    input  wire logic             Reset_n,
    alu_cmd_sequencer_if.slave    seq_if,
    input  wire logic             of_clr,
    output logic                  of_sticky,
    output logic [CNT_W-1:0]      instr_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic              r_cmd_ready;
    logic              r_res_valid;
    logic              w_accept;
    logic              w_retire;
    logic              w_write_reg;

    logic [OP_W-1:0]   r_op;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;

    logic [DATA_W-1:0] r_res_data;
    logic              r_res_zf;
    logic              r_res_of;
    logic              r_res_wrote;
    logic              r_of_sticky;
    logic [CNT_W-1:0]  r_instr_cnt;

    assign w_accept = (r_state == IDLE) && r_cmd_ready && seq_if.cmd_valid;
    assign w_retire = (r_state == RESP) && seq_if.res_ready;

    // The only input-to-output combinational path: ALU overflow gates the write.
    assign w_write_reg = (r_state == EXEC)
                       && !(PROTECT_R0 && is_zero_reg(r_rd))
                       && !(TRAP_ON_OF && seq_if.alu_OF);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (w_retire) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake flags are registered so every output reads 0 while in reset.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_ready <= (w_next_state == IDLE);
            r_res_valid <= (w_next_state == RESP);
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_op        <= '0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_res_data  <= '0;
            r_res_zf    <= 1'b0;
            r_res_of    <= 1'b0;
            r_res_wrote <= 1'b0;
            r_of_sticky <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_op <= seq_if.cmd_op;
                r_rd <= seq_if.cmd_rd;
                r_rs <= seq_if.cmd_rs;
                r_rt <= seq_if.cmd_rt;
            end

            if (r_state == EXEC) begin
                r_res_data  <= seq_if.alu_F;
                r_res_zf    <= seq_if.alu_ZF;
                r_res_of    <= seq_if.alu_OF;
                r_res_wrote <= w_write_reg;
            end

            // A concurrent overflow beats a clear request.
            if ((r_state == EXEC) && seq_if.alu_OF) begin
                r_of_sticky <= 1'b1;
            end else if (of_clr) begin
                r_of_sticky <= 1'b0;
            end

            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + c_cnt_one;
            end
        end
    end

    assign seq_if.cmd_ready = r_cmd_ready;
    assign seq_if.R_Addr_A  = r_rs;
    assign seq_if.R_Addr_B  = r_rt;
    assign seq_if.W_Addr    = r_rd;
    assign seq_if.ALU_OP    = r_op;
    assign seq_if.Write_Reg = w_write_reg;
    assign seq_if.res_valid = r_res_valid;
    assign seq_if.res_data  = r_res_data;
    assign seq_if.res_zf    = r_res_zf;
    assign seq_if.res_of    = r_res_of;
    assign seq_if.res_wrote = r_res_wrote;

    assign of_sticky = r_of_sticky;
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Bench with register file + ALU environment and transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                Reset_n = 1'b0;
    logic                of_clr = 1'b0;
    logic                of_sticky;
    logic [TB_CNT_W-1:0] instr_cnt;

    int checks   = 0;
    int failures = 0;

    alu_cmd_sequencer_if sif();

    alu_cmd_sequencer #(
        .PROTECT_R0 (1'b1),
        .TRAP_ON_OF (1'b1),
        .CNT_W      (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .seq_if    (sif.slave),
        .of_clr    (of_clr),
        .of_sticky (of_sticky),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {OF, F}
    function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] f;
        logic        of;
        f  = '0;
        of = 1'b0;
        case (op)
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_XOR: f = a ^ b;
            OP_INC: begin f = a + 32'd1; of = !a[31] && f[31]; end
            OP_ADD: begin f = a + b; of = (a[31] == b[31]) && (f[31] != a[31]); end
            OP_SUB: begin f = a - b; of = (a[31] != b[31]) && (f[31] != a[31]); end
            OP_SLT: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: f = a << b[4:0];
        endcase
        return {of, f};
    endfunction

    // Environment: register file and ALU around the sequencer
    logic [31:0] rf [32];
    logic        poke_en = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [31:0] poke_val = '0;
    int          wr_pulses = 0;

    assign {sif.alu_OF, sif.alu_F} = alu_fn(sif.ALU_OP, rf[sif.R_Addr_A], rf[sif.R_Addr_B]);
    assign sif.alu_ZF = (sif.alu_F == 32'd0);

    always @(posedge clk) begin
        if (poke_en) rf[poke_addr] <= poke_val;
        else if (sif.Write_Reg) rf[sif.W_Addr] <= sif.alu_F;
    end

    always @(negedge clk) begin
        if (sif.Write_Reg) wr_pulses++;
    end

    // Reference model at transaction level
    logic [31:0] m_regs [32];
    logic        m_sticky = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] v);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_val  = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
        m_regs[a] = v;
        @(negedge clk);
    endtask

    task automatic drive_junk();
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = 3'($urandom_range(0, 7));
        sif.cmd_rd    = 5'($urandom_range(0, 31));
        sif.cmd_rs    = 5'($urandom_range(0, 31));
        sif.cmd_rt    = 5'($urandom_range(0, 31));
    endtask

    // Waits (bounded) for cmd_ready, then issues one command; returns in EXEC+1ns
    task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        int n;
        n = 0;
        while (!sif.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("cmd_ready_timeout", {31'd0, sif.cmd_ready}, 32'd1);
        end
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = op;
        sif.cmd_rd    = rd;
        sif.cmd_rs    = rs;
        sif.cmd_rt    = rt;
        @(posedge clk);
        #1 drive_junk();
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input int hold, input bit clr_in_exec);
        logic [32:0] r;
        logic        exp_wrote;
        logic        exp_sticky;
        int          p0;
        r          = alu_fn(op, m_regs[rs], m_regs[rt]);
        exp_wrote  = (rd != 5'd0) && !r[32];
        exp_sticky = r[32] ? 1'b1 : (clr_in_exec ? 1'b0 : m_sticky);
        p0         = wr_pulses;
        issue(op, rd, rs, rt);
        @(negedge clk);
        of_clr = clr_in_exec;
        chk("exec_write_reg", {31'd0, sif.Write_Reg}, {31'd0, exp_wrote});
        chk("exec_addr_a", {27'd0, sif.R_Addr_A}, {27'd0, rs});
        chk("exec_addr_b", {27'd0, sif.R_Addr_B}, {27'd0, rt});
        chk("exec_w_addr", {27'd0, sif.W_Addr}, {27'd0, rd});
        chk("exec_alu_op", {29'd0, sif.ALU_OP}, {29'd0, op});
        chk("exec_cmd_ready", {31'd0, sif.cmd_ready}, 32'd0);
        @(posedge clk);
        #1 of_clr = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive_junk();
            chk("hold_res_valid", {31'd0, sif.res_valid}, 32'd1);
            chk("hold_cmd_ready", {31'd0, sif.cmd_ready}, 32'd0);
            chk("hold_res_data", sif.res_data, r[31:0]);
            chk("hold_write_reg", {31'd0, sif.Write_Reg}, 32'd0);
        end
        @(negedge clk);
        sif.cmd_valid = 1'b0;
        sif.res_ready = 1'b1;
        chk("res_valid", {31'd0, sif.res_valid}, 32'd1);
        chk("res_data", sif.res_data, r[31:0]);
        chk("res_zf", {31'd0, sif.res_zf}, {31'd0, (r[31:0] == 32'd0)});
        chk("res_of", {31'd0, sif.res_of}, {31'd0, r[32]});
        chk("res_wrote", {31'd0, sif.res_wrote}, {31'd0, exp_wrote});
        chk("of_sticky", {31'd0, of_sticky}, {31'd0, exp_sticky});
        chk("write_pulses", 32'(wr_pulses - p0), exp_wrote ? 32'd1 : 32'd0);
        if (exp_wrote) m_regs[rd] = r[31:0];
        m_sticky = exp_sticky;
        m_cnt    = m_cnt + 1;
        @(posedge clk);
        #1 sif.res_ready = 1'b0;
        @(negedge clk);
        chk("instr_cnt", {28'd0, instr_cnt}, 32'(m_cnt % (1 << TB_CNT_W)));
        chk("ready_after_retire", {31'd0, sif.cmd_ready}, 32'd1);
        chk("rf_dest", rf[rd], m_regs[rd]);
    endtask

    task automatic clear_sticky();
        of_clr = 1'b1;
        @(posedge clk);
        #1 of_clr = 1'b0;
        m_sticky = 1'b0;
        @(negedge clk);
        chk("of_clr", {31'd0, of_sticky}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, sif.cmd_ready}, 32'd0);
        chk({tag, "_write_reg"}, {31'd0, sif.Write_Reg}, 32'd0);
        chk({tag, "_addr"}, {17'd0, sif.R_Addr_A, sif.R_Addr_B, sif.W_Addr}, 32'd0);
        chk({tag, "_alu_op"}, {29'd0, sif.ALU_OP}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, sif.res_valid}, 32'd0);
        chk({tag, "_res_data"}, sif.res_data, 32'd0);
        chk({tag, "_res_flags"}, {29'd0, sif.res_zf, sif.res_of, sif.res_wrote}, 32'd0);
        chk({tag, "_of_sticky"}, {31'd0, of_sticky}, 32'd0);
        chk({tag, "_instr_cnt"}, {28'd0, instr_cnt}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.cmd_valid = 1'b0;
        sif.cmd_op    = '0;
        sif.cmd_rd    = '0;
        sif.cmd_rs    = '0;
        sif.cmd_rt    = '0;
        sif.res_ready = 1'b0;
        #1;
        chk_all_zero("reset");

        // Seed the register file while held in reset
        for (int i = 0; i < 32; i++) begin
            poke(5'(i), (i < 8) ? 32'd0 : $urandom);
        end
        Reset_n = 1'b1;
        @(negedge clk);

        run_cmd(OP_ADD, 5'd1, 5'd0, 5'd0, 0, 1'b0);
        run_cmd(OP_INC, 5'd2, 5'd0, 5'd9, 0, 1'b0);
        run_cmd(OP_INC, 5'd3, 5'd2, 5'd9, 0, 1'b0);
        run_cmd(OP_ADD, 5'd4, 5'd2, 5'd3, 0, 1'b0);
        chk("seed_r4", rf[4], 32'd3);

        poke(5'd5, 32'h7FFF_FFFF);
        poke(5'd6, 32'd1);
        run_cmd(OP_ADD, 5'd7, 5'd5, 5'd6, 0, 1'b0);
        chk("trap_r7_unchanged", rf[7], 32'd0);
        clear_sticky();

        run_cmd(OP_XOR, 5'd0, 5'd2, 5'd3, 0, 1'b0);
        chk("r0_protected", rf[0], 32'd0);

        run_cmd(OP_SUB, 5'd8, 5'd4, 5'd2, 5, 1'b0);
        run_cmd(OP_ADD, 5'd7, 5'd5, 5'd6, 0, 1'b1);
        clear_sticky();

        for (int k = 0; k < 30; k++) begin
            run_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset during EXEC aborts the write
        issue(OP_INC, 5'd9, 5'd4, 5'd0);
        @(negedge clk);
        #2 Reset_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        sif.cmd_valid = 1'b0;
        @(posedge clk);
        #1 chk("mid_reset_no_write", rf[9], m_regs[9]);
        m_cnt    = 0;
        m_sticky = 1'b0;
        @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, sif.cmd_ready}, 32'd1);
        run_cmd(OP_OR, 5'd10, 5'd4, 5'd2, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
